barcode_tx: RTL

Barcode waveform generator: serializes an 8-bit station ID onto a single active-low stripe line (`BC`), using the same pulse-width protocol the robot's barcode reader decodes. It is used as the track-side or bench stimulus source, driving the reader's `BC` input in system simulation and on the FPGA test fixture. Stripe timing is set per transmission through a runtime unit period, so reader tolerance to different robot speeds can be exercised.

---
 rtl/barcode_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/barcode_tx.sv
// Barcode stripe generator: serializes an 8-bit ID, MSB first, as active-low
// pulse-width cells on BC (start bit 2P/2P, '1' = P/3P, '0' = 3P/P).
module barcode_tx #(
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             send,
  input  logic [7:0]       tx_id,
  input  logic [CNT_W-1:0] period,
  output logic             BC,
  output logic             busy,
  output logic             done
);

  localparam int CW = CNT_W + 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START_LO = 3'd1,
    START_HI = 3'd2,
    BIT_LO   = 3'd3,
    BIT_HI   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] p_reg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    p1;
  logic [CW-1:0]    p2;
  logic [CW-1:0]    p3;
  logic [CW-1:0]    target;
  logic [7:0]       shreg;
  logic [3:0]       bit_cnt;
  logic             phase_end;

  // Two extra counter bits keep 3P exact for the largest period.
  always_comb begin
    p1 = {2'b00, p_reg};
    p2 = p1 << 1;
    p3 = p2 + p1;
  end

  always_comb begin
    target = p1;
    case (state)
      START_LO, START_HI: target = p2;
      BIT_LO:             target = shreg[7] ? p1 : p3;
      BIT_HI:             target = shreg[7] ? p3 : p1;
      default:            target = p1;
    endcase
  end

  always_comb begin
    state_next = state;
    phase_end  = (state != IDLE) && (cnt == target);
    busy       = (state != IDLE);
    done       = (state == BIT_HI) && phase_end && (bit_cnt == 4'd7);
    case (state)
      IDLE:     if (send) state_next = START_LO;
      START_LO: if (phase_end) state_next = START_HI;
      START_HI: if (phase_end) state_next = BIT_LO;
      BIT_LO:   if (phase_end) state_next = BIT_HI;
      BIT_HI:   if (phase_end) state_next = (bit_cnt == 4'd7) ? IDLE : BIT_LO;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      BC      <= 1'b1;
      cnt     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      p_reg   <= '0;
    end else begin
      state <= state_next;
      // BC follows the state being entered so it lines up with that state.
      BC    <= !((state_next == START_LO) || (state_next == BIT_LO));

      if (state_next == IDLE)
        cnt <= '0;
      else if (state_next != state)
        cnt <= CW'(1);
      else
        cnt <= cnt + CW'(1);

      if ((state == IDLE) && send) begin
        shreg   <= tx_id;
        p_reg   <= (period == '0) ? CNT_W'(1) : period;
        bit_cnt <= '0;
      end else if ((state == BIT_HI) && phase_end) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
      end
    end
  end

endmodule
